// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the dot-product sequencer.
package mac_pkg;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 26;

   typedef enum logic [2:0] {IDLE, CLR, FETCH, DRAIN, OUT} state_t;
endpackage

// File: rtl/sat_relu.sv
// Scales the accumulator by an arithmetic right shift (floor), then clamps it
// to the signed 8-bit range, optionally zeroing negatives.
import mac_pkg::*;

module sat_relu #(
   parameter int SHIFT = 7,
   parameter int RELU  = 0
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic signed [DATA_W-1:0] o_res
);

   localparam logic signed [ACC_W-1:0] MAX_V = 127;
   localparam logic signed [ACC_W-1:0] MIN_V = -128;

   logic signed [ACC_W-1:0] w_sh;

   assign w_sh = i_acc >>> SHIFT;

   always_comb begin
      o_res = w_sh[DATA_W-1:0];
      if (RELU != 0 && w_sh < 0)
         o_res = '0;
      else if (w_sh > MAX_V)
         o_res = 8'sd127;
      else if (w_sh < MIN_V)
         o_res = -8'sd128;
   end

endmodule

// File: rtl/mac_seq.sv
// Sequences one dot product: streams len operand pairs from two memories into
// an external MAC, then saturates the accumulator into an 8-bit result.
import mac_pkg::*;

module mac_seq #(
   parameter int SHIFT  = 7,
   parameter int RELU   = 0,
   parameter int ADDR_W = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        len,
   input  logic [ADDR_W-1:0]        in_base,
   input  logic [ADDR_W-1:0]        wt_base,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        in_addr,
   output logic [ADDR_W-1:0]        wt_addr,
   input  logic signed [DATA_W-1:0] in_rd_data,
   input  logic signed [DATA_W-1:0] wt_rd_data,
   output logic signed [DATA_W-1:0] mac_in1,
   output logic signed [DATA_W-1:0] mac_in2,
   output logic                     mac_clr,
   input  logic signed [ACC_W-1:0]  mac_acc,
   output logic signed [DATA_W-1:0] result,
   output logic                     result_vld,
   output logic                     busy
);

   state_t                   r_state;
   logic [ADDR_W-1:0]        r_len, r_in_base, r_wt_base, r_k;
   logic [ADDR_W-1:0]        r_in_addr, r_wt_addr;
   logic                     r_rd_en, r_vld, r_clr, r_busy, r_res_vld;
   logic signed [DATA_W-1:0] r_result;
   logic signed [DATA_W-1:0] w_sat;

   sat_relu #(.SHIFT(SHIFT), .RELU(RELU)) u_sat (
      .i_acc (mac_acc),
      .o_res (w_sat)
   );

   // r_k is the next index to issue; CLR has already issued index 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_len     <= '0;
         r_in_base <= '0;
         r_wt_base <= '0;
         r_k       <= '0;
         r_in_addr <= '0;
         r_wt_addr <= '0;
         r_rd_en   <= 1'b0;
         r_vld     <= 1'b0;
         r_clr     <= 1'b0;
         r_busy    <= 1'b0;
         r_res_vld <= 1'b0;
         r_result  <= '0;
      end else begin
         r_vld     <= r_rd_en;
         r_res_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && len != '0) begin
                  r_state   <= CLR;
                  r_len     <= len;
                  r_in_base <= in_base;
                  r_wt_base <= wt_base;
                  r_k       <= ADDR_W'(1);
                  r_in_addr <= in_base;
                  r_wt_addr <= wt_base;
                  r_rd_en   <= 1'b1;
                  r_clr     <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            CLR, FETCH: begin
               r_clr <= 1'b0;
               if (r_k == r_len) begin
                  r_state <= DRAIN;
                  r_rd_en <= 1'b0;
               end else begin
                  r_state   <= FETCH;
                  r_rd_en   <= 1'b1;
                  r_in_addr <= r_in_base + r_k;
                  r_wt_addr <= r_wt_base + r_k;
                  r_k       <= r_k + 1'b1;
               end
            end
            DRAIN: r_state <= OUT;
            OUT: begin
               r_result  <= w_sat;
               r_res_vld <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rd_en      = r_rd_en;
   assign in_addr    = r_in_addr;
   assign wt_addr    = r_wt_addr;
   assign mac_clr    = r_clr;
   assign busy       = r_busy;
   assign result     = r_result;
   assign result_vld = r_res_vld;
   // Memory data lands one cycle after the read; pass it only in that cycle.
   assign mac_in1    = r_vld ? in_rd_data : '0;
   assign mac_in2    = r_vld ? wt_rd_data : '0;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: two instances (RELU off/on) with behavioural memories and
// MACs, checked against a dot-product reference computed from memory contents.
module tb_mac_seq;

   localparam int W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [9:0] len = '0, in_base = '0, wt_base = '0;

   logic rd0, rd1, clr0, clr1, vld0, vld1, busy0, busy1;
   logic [9:0] ia0, wa0, ia1, wa1;
   logic signed [7:0] m1_0, m2_0, m1_1, m2_1, res0, res1;
   logic signed [7:0] ird0 = 0, wrd0 = 0, ird1 = 0, wrd1 = 0;
   logic signed [25:0] acc0 = 0, acc1 = 0;

   logic signed [7:0] in_mem [1024];
   logic signed [7:0] wt_mem [1024];

   int checks = 0;
   int errors = 0;

   logic              cap_rd [W], cap_vld0 [W], cap_vld1 [W], cap_busy [W], cap_clr [W];
   logic [9:0]        cap_ia [W], cap_wa [W];
   logic signed [7:0] cap_m1 [W], cap_m2 [W], cap_res0 [W], cap_res1 [W];
   logic signed [25:0] cap_acc [W];

   always #5 clk = ~clk;

   mac_seq #(.SHIFT(7), .RELU(0), .ADDR_W(10)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_base(in_base), .wt_base(wt_base),
      .rd_en(rd0), .in_addr(ia0), .wt_addr(wa0), .in_rd_data(ird0), .wt_rd_data(wrd0),
      .mac_in1(m1_0), .mac_in2(m2_0), .mac_clr(clr0), .mac_acc(acc0),
      .result(res0), .result_vld(vld0), .busy(busy0));

   mac_seq #(.SHIFT(7), .RELU(1), .ADDR_W(10)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_base(in_base), .wt_base(wt_base),
      .rd_en(rd1), .in_addr(ia1), .wt_addr(wa1), .in_rd_data(ird1), .wt_rd_data(wrd1),
      .mac_in1(m1_1), .mac_in2(m2_1), .mac_clr(clr1), .mac_acc(acc1),
      .result(res1), .result_vld(vld1), .busy(busy1));

   always @(posedge clk) begin
      if (rd0) begin ird0 <= in_mem[ia0]; wrd0 <= wt_mem[wa0]; end
      if (rd1) begin ird1 <= in_mem[ia1]; wrd1 <= wt_mem[wa1]; end
      acc0 <= clr0 ? 26'sd0 : acc0 + m1_0 * m2_0;
      acc1 <= clr1 ? 26'sd0 : acc1 + m1_1 * m2_1;
   end

   function automatic longint ref_dot(input int l, input int ib, input int wb);
      longint s = 0;
      for (int k = 0; k < l; k++)
         s += longint'(in_mem[(ib + k) % 1024]) * longint'(wt_mem[(wb + k) % 1024]);
      return s;
   endfunction

   function automatic int ref_sat(input longint s, input bit relu);
      longint q = s / 128;
      if (s < 0 && (s % 128) != 0) q = q - 1;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      if (relu && q < 0) q = 0;
      return int'(q);
   endfunction

   // Pulse start (sampled at "edge 0"), then record cycle n = cycle after edge n.
   task automatic do_op(input int l, input int ib, input int wb, input int extra_at, input int extra_len);
      @(negedge clk);
      start = 1'b1; len = 10'(l); in_base = 10'(ib); wt_base = 10'(wb);
      for (int n = 0; n < W; n++) begin
         @(negedge clk);
         if (n == extra_at) begin start = 1'b1; len = 10'(extra_len); end
         else start = 1'b0;
         cap_rd[n] = rd0;     cap_ia[n] = ia0;     cap_wa[n] = wa0;
         cap_vld0[n] = vld0;  cap_vld1[n] = vld1;  cap_busy[n] = busy0;
         cap_clr[n] = clr0;   cap_m1[n] = m1_0;    cap_m2[n] = m2_0;
         cap_res0[n] = res0;  cap_res1[n] = res1;  cap_acc[n] = acc0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd0, clr0, vld0, busy0, rd1, clr1, vld1, busy1} !== 8'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 0", {rd0, clr0, vld0, busy0, rd1, clr1, vld1, busy1});
      end
      checks++;
      if ({ia0, wa0, m1_0, m2_0, res0} !== 44'b0) begin
         errors++; $display("FAIL reset_data got ia=%0d wa=%0d m1=%0d m2=%0d res=%0d exp 0", ia0, wa0, m1_0, m2_0, res0);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      in_mem[100] = 8'sd64; wt_mem[200] = 8'sd64;
      do_op(1, 100, 200, -1, 0);
      checks++;
      if (cap_acc[2] !== 26'sd4096) begin errors++; $display("FAIL basic_acc got %0d exp 4096", cap_acc[2]); end
      for (int n = 0; n < 6; n++) begin
         checks++;
         if (cap_vld0[n] !== (n == 3)) begin errors++; $display("FAIL basic_vld n=%0d got %b exp %b", n, cap_vld0[n], n == 3); end
         checks++;
         if (cap_clr[n] !== (n == 0)) begin errors++; $display("FAIL basic_clr n=%0d got %b exp %b", n, cap_clr[n], n == 0); end
      end
      checks++;
      if (cap_res0[3] !== 8'sd32) begin errors++; $display("FAIL basic_result got %0d exp 32", cap_res0[3]); end
   endtask

   task automatic test_saturate;
      for (int k = 0; k < 4; k++) begin in_mem[300 + k] = 8'sd127; wt_mem[400 + k] = 8'sd127; end
      do_op(4, 300, 400, -1, 0);
      checks++;
      if (cap_acc[5] !== 26'sd64516) begin errors++; $display("FAIL sat_acc got %0d exp 64516", cap_acc[5]); end
      checks++;
      if (cap_vld0[6] !== 1'b1 || cap_res0[6] !== 8'sd127) begin
         errors++; $display("FAIL sat_pos got vld=%b res=%0d exp vld=1 res=127", cap_vld0[6], cap_res0[6]);
      end
      checks++;
      if (cap_res1[6] !== 8'sd127) begin errors++; $display("FAIL sat_pos_relu got %0d exp 127", cap_res1[6]); end
   endtask

   task automatic test_negative;
      for (int k = 0; k < 2; k++) begin in_mem[500 + k] = -8'sd128; wt_mem[600 + k] = 8'sd127; end
      do_op(2, 500, 600, -1, 0);
      checks++;
      if (cap_acc[3] !== -26'sd32512) begin errors++; $display("FAIL neg_acc got %0d exp -32512", cap_acc[3]); end
      checks++;
      if (cap_vld0[4] !== 1'b1 || cap_res0[4] !== -8'sd128) begin
         errors++; $display("FAIL neg_sat got vld=%b res=%0d exp vld=1 res=-128", cap_vld0[4], cap_res0[4]);
      end
      checks++;
      if (cap_vld1[4] !== 1'b1 || cap_res1[4] !== 8'sd0) begin
         errors++; $display("FAIL neg_relu got vld=%b res=%0d exp vld=1 res=0", cap_vld1[4], cap_res1[4]);
      end
   endtask

   task automatic test_wrap;
      do_op(8, 0, 1020, -1, 0);
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (cap_rd[n] !== 1'b1 || cap_ia[n] !== 10'(n) || cap_wa[n] !== 10'((1020 + n) % 1024)) begin
            errors++;
            $display("FAIL wrap_addr n=%0d got rd=%b ia=%0d wa=%0d exp rd=1 ia=%0d wa=%0d",
                     n, cap_rd[n], cap_ia[n], cap_wa[n], n, (1020 + n) % 1024);
         end
      end
      checks++;
      if (cap_res0[10] !== 8'(ref_sat(ref_dot(8, 0, 1020), 1'b0))) begin
         errors++; $display("FAIL wrap_result got %0d exp %0d", cap_res0[10], ref_sat(ref_dot(8, 0, 1020), 1'b0));
      end
   endtask

   task automatic test_ignore;
      int nv, nb, nr;
      do_op(0, 10, 20, -1, 0);
      nv = 0; nb = 0; nr = 0;
      for (int n = 0; n < W; n++) begin nv += int'(cap_vld0[n]); nb += int'(cap_busy[n]); nr += int'(cap_rd[n]); end
      checks++;
      if (nv != 0 || nb != 0 || nr != 0) begin
         errors++; $display("FAIL ignore_len0 got vld=%0d busy=%0d rd=%0d exp 0 0 0", nv, nb, nr);
      end
      do_op(5, 10, 20, 2, 3);
      nv = 0; nr = 0;
      for (int n = 0; n < W; n++) begin
         nv += int'(cap_vld0[n]); nr += int'(cap_rd[n]);
         checks++;
         if (cap_busy[n] !== (n <= 6)) begin errors++; $display("FAIL ignore_busy n=%0d got %b exp %b", n, cap_busy[n], n <= 6); end
      end
      checks++;
      if (nv != 1 || cap_vld0[7] !== 1'b1 || nr != 5) begin
         errors++; $display("FAIL ignore_busy_start got vld_cnt=%0d vld7=%b rd_cnt=%0d exp 1 1 5", nv, cap_vld0[7], nr);
      end
   endtask

   task automatic test_abort;
      int nv;
      @(negedge clk);
      start = 1'b1; len = 10'd10; in_base = 10'd50; wt_base = 10'd60;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rd0, clr0, vld0, busy0} !== 4'b0 || {ia0, wa0, m1_0, m2_0, res0} !== 44'b0) begin
         errors++; $display("FAIL abort_outputs got rd=%b clr=%b vld=%b busy=%b ia=%0d wa=%0d m1=%0d m2=%0d res=%0d exp 0",
                            rd0, clr0, vld0, busy0, ia0, wa0, m1_0, m2_0, res0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      for (int n = 0; n < 20; n++) begin @(negedge clk); nv += int'(vld0) + int'(vld1); end
      checks++;
      if (nv != 0) begin errors++; $display("FAIL abort_no_vld got %0d exp 0", nv); end
      in_mem[100] = 8'sd64; wt_mem[200] = 8'sd64;
      do_op(1, 100, 200, -1, 0);
      checks++;
      if (cap_vld0[3] !== 1'b1 || cap_res0[3] !== 8'sd32) begin
         errors++; $display("FAIL abort_rerun got vld=%b res=%0d exp vld=1 res=32", cap_vld0[3], cap_res0[3]);
      end
   endtask

   task automatic test_random;
      int l, ib, wb, e0, e1;
      for (int it = 0; it < 20; it++) begin
         l  = $urandom_range(1, 20);
         ib = $urandom_range(0, 1023);
         wb = $urandom_range(0, 1023);
         for (int k = 0; k < l; k++) begin
            in_mem[(ib + k) % 1024] = 8'($urandom);
            wt_mem[(wb + k) % 1024] = 8'($urandom);
         end
         e0 = ref_sat(ref_dot(l, ib, wb), 1'b0);
         e1 = ref_sat(ref_dot(l, ib, wb), 1'b1);
         do_op(l, ib, wb, -1, 0);
         for (int n = 0; n < l + 8; n++) begin
            checks++;
            if (cap_rd[n] !== (n < l) || (n < l && (cap_ia[n] !== 10'((ib + n) % 1024) || cap_wa[n] !== 10'((wb + n) % 1024)))) begin
               errors++; $display("FAIL rand_rd it=%0d n=%0d got rd=%b ia=%0d wa=%0d exp rd=%b ia=%0d wa=%0d",
                                  it, n, cap_rd[n], cap_ia[n], cap_wa[n], n < l, (ib + n) % 1024, (wb + n) % 1024);
            end
            checks++;
            if (n >= 1 && n <= l) begin
               if (cap_m1[n] !== in_mem[(ib + n - 1) % 1024] || cap_m2[n] !== wt_mem[(wb + n - 1) % 1024]) begin
                  errors++; $display("FAIL rand_operand it=%0d n=%0d got %0d,%0d exp %0d,%0d", it, n, cap_m1[n], cap_m2[n],
                                     in_mem[(ib + n - 1) % 1024], wt_mem[(wb + n - 1) % 1024]);
               end
            end else if (cap_m1[n] !== 8'sd0 || cap_m2[n] !== 8'sd0) begin
               errors++; $display("FAIL rand_operand_idle it=%0d n=%0d got %0d,%0d exp 0,0", it, n, cap_m1[n], cap_m2[n]);
            end
            checks++;
            if (cap_vld0[n] !== (n == l + 2) || cap_vld1[n] !== (n == l + 2) ||
                cap_busy[n] !== (n <= l + 1) || cap_clr[n] !== (n == 0)) begin
               errors++; $display("FAIL rand_ctrl it=%0d n=%0d got vld=%b%b busy=%b clr=%b exp vld=%b busy=%b clr=%b",
                                  it, n, cap_vld0[n], cap_vld1[n], cap_busy[n], cap_clr[n], n == l + 2, n <= l + 1, n == 0);
            end
            if (n >= l + 2) begin
               checks++;
               if (cap_res0[n] !== 8'(e0) || cap_res1[n] !== 8'(e1)) begin
                  errors++; $display("FAIL rand_result it=%0d n=%0d got %0d,%0d exp %0d,%0d", it, n, cap_res0[n], cap_res1[n], e0, e1);
               end
            end
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) begin in_mem[a] = 8'($urandom); wt_mem[a] = 8'($urandom); end
      test_reset;
      test_basic;
      test_saturate;
      test_negative;
      test_wrap;
      test_ignore;
      test_abort;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
